// File: rtl/mem_pkg.sv
// Shared constants and FSM state encoding for the memory responder.
package mem_pkg;
   localparam int WORD_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;
endpackage

// File: rtl/mem_array.sv
// Word storage with a synchronous write port and a registered, resettable read port.
module mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem [DEPTH];

   // Contents survive reset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[idx];
   end
endmodule

// File: rtl/mem_responder.sv
// Request/ack memory responder with programmable wait states.
// Optional address error reporting is enabled with MEM_ERR_EN.
//
// state     | meaning
// ST_IDLE   | waiting for req; captures the request
// ST_WAIT   | counting down wait states
// ST_ACCESS | performing the store or load
// ST_RESP   | one-cycle ack
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [31:0]       addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata,
   output logic              ack,
`ifdef MEM_ERR_EN
   output logic              err,
`endif
   output logic              busy
);
   localparam int               IDX_W   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx_q;
   logic               we_q;
   logic [WORD_W-1:0]  wdata_q;
   logic               access_ok;
   logic               mem_we;
   logic               mem_re;

`ifdef MEM_ERR_EN
   logic bad_q;
   logic addr_bad;

   assign addr_bad  = (addr[1:0] != 2'b00) || (addr[31:IDX_W+2] != '0);
   assign access_ok = !bad_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bad_q <= 1'b0;
         err   <= 1'b0;
      end else begin
         if (state == ST_IDLE && req) bad_q <= addr_bad;
         if (state == ST_ACCESS)      err   <= bad_q;
      end
   end
`else
   // Offset and high address bits are deliberately ignored so addresses alias.
   logic unused_addr;
   assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};
   assign access_ok   = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && req) begin
            idx_q   <= addr[IDX_W+1:2];
            we_q    <= we;
            wdata_q <= wdata;
            cnt     <= WAIT_LD;
         end else if (state == ST_WAIT) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (req) state_nx = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
         ST_WAIT:   if (cnt == CNT_W'(1)) state_nx = ST_ACCESS;
         ST_ACCESS: state_nx = ST_RESP;
         ST_RESP:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   assign mem_we = (state == ST_ACCESS) && we_q && access_ok;
   assign mem_re = (state == ST_ACCESS) && !we_q && access_ok;
   assign ack    = (state == ST_RESP);
   assign busy   = (state != ST_IDLE);

   mem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .re    (mem_re),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (rdata)
   );
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: u2 has two wait states, u0 has none.
module tb_mem_responder;
   logic        clk = 1'b0;
   logic        reset;
   logic        req2, req0, we;
   logic [31:0] addr, wdata;
   logic [31:0] rdata2, rdata0;
   logic        ack2, ack0, busy2, busy0;
`ifdef MEM_ERR_EN
   logic        err2, err0;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u2 (
      .clk   (clk),
      .reset (reset),
      .req   (req2),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata2),
      .ack   (ack2),
`ifdef MEM_ERR_EN
      .err   (err2),
`endif
      .busy  (busy2)
   );

   mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u0 (
      .clk   (clk),
      .reset (reset),
      .req   (req0),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata0),
      .ack   (ack0),
`ifdef MEM_ERR_EN
      .err   (err0),
`endif
      .busy  (busy0)
   );

   // One transfer on u2; inputs are scrambled right after capture.
   task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic e);
      @(negedge clk);
      req2 = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk);
      #1;
      addr = 32'hFFFF_FFFC ^ a; wdata = ~d; we = ~w;
      lat = -1;
      e   = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (ack2) begin
            lat = k;
`ifdef MEM_ERR_EN
            e = err2;
`endif
            break;
         end
      end
      req2 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req2 = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", rdata2, 32'h0); end
      checks++; if (ack2 !== 1'b0)    begin errors++; $display("FAIL reset_ack: got %b expected 0", ack2); end
      checks++; if (busy2 !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy2); end
`ifdef MEM_ERR_EN
      checks++; if (err2 !== 1'b0)    begin errors++; $display("FAIL reset_err: got %b expected 0", err2); end
`endif
      reset = 1'b0;
   endtask

   task automatic test_store_load();
      int   lat;
      logic e;
      do_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, lat, e);
      checks++; if (lat !== 4) begin errors++; $display("FAIL store_latency: got %0d expected 4", lat); end
      do_xfer(1'b0, 32'h10, 32'h0, lat, e);
      checks++; if (lat !== 4) begin errors++; $display("FAIL load_latency: got %0d expected 4", lat); end
      checks++; if (rdata2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data: got %h expected %h", rdata2, 32'hDEAD_BEEF); end
`ifdef MEM_ERR_EN
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", e); end
`endif
      do_xfer(1'b1, 32'h14, 32'h0BAD_F00D, lat, e);
      repeat (3) @(negedge clk);
      checks++; if (rdata2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rdata_hold: got %h expected %h", rdata2, 32'hDEAD_BEEF); end
   endtask

   task automatic test_zero_wait();
      int lat = -1;
      int busy_cnt = 0;
      @(negedge clk);
      req0 = 1'b1; we = 1'b0; addr = 32'h0;
      @(posedge clk);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (busy0) busy_cnt++;
         if (ack0 && lat < 0) begin
            lat  = k;
            req0 = 1'b0;
         end
      end
      req0 = 1'b0;
      checks++; if (lat !== 2)      begin errors++; $display("FAIL zero_wait_latency: got %0d expected 2", lat); end
      checks++; if (busy_cnt !== 2) begin errors++; $display("FAIL zero_wait_busy: got %0d expected 2", busy_cnt); end
   endtask

`ifndef MEM_ERR_EN
   task automatic test_alias();
      int   lat;
      logic e;
      do_xfer(1'b1, 32'h004, 32'h1234_5678, lat, e);
      do_xfer(1'b0, 32'h404, 32'h0, lat, e);
      checks++; if (lat !== 4) begin errors++; $display("FAIL alias_latency: got %0d expected 4", lat); end
      checks++; if (rdata2 !== 32'h1234_5678) begin errors++; $display("FAIL alias_data: got %h expected %h", rdata2, 32'h1234_5678); end
   endtask
`else
   task automatic test_err();
      int   lat;
      logic e;
      do_xfer(1'b0, 32'h14, 32'h0, lat, e);
      checks++; if (rdata2 !== 32'h0BAD_F00D) begin errors++; $display("FAIL err_pre_load: got %h expected %h", rdata2, 32'h0BAD_F00D); end
      do_xfer(1'b0, 32'h13, 32'h0, lat, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_misaligned: got %b expected 1", e); end
      checks++; if (rdata2 !== 32'h0BAD_F00D) begin errors++; $display("FAIL err_rdata_kept: got %h expected %h", rdata2, 32'h0BAD_F00D); end
      do_xfer(1'b0, 32'h400, 32'h0, lat, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_range: got %b expected 1", e); end
      checks++; if (lat !== 4)  begin errors++; $display("FAIL err_latency: got %0d expected 4", lat); end
      do_xfer(1'b0, 32'h10, 32'h0, lat, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL err_legal: got %b expected 0", e); end
      checks++; if (rdata2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_legal_data: got %h expected %h", rdata2, 32'hDEAD_BEEF); end
   endtask
`endif

   task automatic test_reset_abort();
      int   lat;
      int   acks = 0;
      logic e;
      do_xfer(1'b1, 32'h20, 32'h1111_2222, lat, e);
      do_xfer(1'b0, 32'h10, 32'h0, lat, e);
      @(negedge clk);
      req2 = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAA_5555;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (ack2 !== 1'b0)    begin errors++; $display("FAIL abort_ack: got %b expected 0", ack2); end
      checks++; if (busy2 !== 1'b0)   begin errors++; $display("FAIL abort_busy: got %b expected 0", busy2); end
      checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected %h", rdata2, 32'h0); end
      req2 = 1'b0;
      repeat (3) begin @(negedge clk); if (ack2) acks++; end
      reset = 1'b0;
      repeat (6) begin @(negedge clk); if (ack2) acks++; end
      checks++; if (acks !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d expected 0", acks); end
      do_xfer(1'b0, 32'h20, 32'h0, lat, e);
      checks++; if (rdata2 !== 32'h1111_2222) begin errors++; $display("FAIL abort_no_write: got %h expected %h", rdata2, 32'h1111_2222); end
   endtask

   task automatic test_back_to_back();
      int t[3];
      int n_ack = 0;
      t = '{-1, -1, -1};
      @(negedge clk);
      req2 = 1'b1; we = 1'b0; addr = 32'h10;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (ack2) begin
            if (n_ack < 3) t[n_ack] = k;
            n_ack++;
            if (n_ack == 3) req2 = 1'b0;
         end
      end
      req2 = 1'b0;
      checks++; if (n_ack !== 3)       begin errors++; $display("FAIL b2b_count: got %0d expected 3", n_ack); end
      checks++; if (t[0] !== 4)        begin errors++; $display("FAIL b2b_first: got %0d expected 4", t[0]); end
      checks++; if (t[1] - t[0] !== 5) begin errors++; $display("FAIL b2b_gap1: got %0d expected 5", t[1] - t[0]); end
      checks++; if (t[2] - t[1] !== 5) begin errors++; $display("FAIL b2b_gap2: got %0d expected 5", t[2] - t[1]); end
      checks++; if (busy2 !== 1'b0)    begin errors++; $display("FAIL b2b_idle: got %b expected 0", busy2); end
      checks++; if (rdata2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_data: got %h expected %h", rdata2, 32'hDEAD_BEEF); end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_zero_wait();
`ifndef MEM_ERR_EN
      test_alias();
`else
      test_err();
`endif
      test_reset_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
